mdu: RTL and testbench

Multiply/divide unit for the E stage of the five-stage MIPS core. It executes the 4-bit MDU operation code and its `start` strobe from the control unit: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It owns the HI/LO register pair and runs a parametrised multi-cycle busy window. It drives `busy`, which the hazard unit uses to stall MDU instructions in D.

---
 rtl/mdu.sv | 143 ++++++++++++++
 tb/tb_mdu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the E stage.
// Owns HI/LO and holds results back for a fixed multi-cycle busy window.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [WIDTH-1:0] ONE     = 1;
    localparam logic [CW-1:0]    CNT_ONE = 1;
    localparam logic [CW-1:0]    CNT_MUL = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    CNT_DIV = CW'(DIV_CYCLES);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // set when the in-flight op is a divide by zero: suppresses the commit
    logic             dz_q, dz_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               is_sdiv, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, dvd, dvs, dvs_safe;
    logic [WIDTH-1:0]   q_u, r_u, quot, rem;

    // Full-width signed and unsigned products of the live operands
    always_comb begin
        prod_s = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val}) *
                 $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
        prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
    end

    // One unsigned divider on magnitudes; signs restored afterwards.
    // The most negative dividend has magnitude 2^(W-1) as unsigned, so
    // the overflow case falls out as quotient -2^(W-1), remainder 0.
    always_comb begin
        is_sdiv  = (mdu_op == OP_DIV);
        a_neg    = rs_val[WIDTH-1];
        b_neg    = rt_val[WIDTH-1];
        abs_a    = a_neg ? (~rs_val + ONE) : rs_val;
        abs_b    = b_neg ? (~rt_val + ONE) : rt_val;
        dvd      = is_sdiv ? abs_a : rs_val;
        dvs      = is_sdiv ? abs_b : rt_val;
        dvs_safe = (rt_val == '0) ? ONE : dvs;
        q_u      = dvd / dvs_safe;
        r_u      = dvd % dvs_safe;
        quot     = (is_sdiv && (a_neg ^ b_neg)) ? (~q_u + ONE) : q_u;
        rem      = (is_sdiv && a_neg) ? (~r_u + ONE) : r_u;
    end

    // Next state: count down in RUN and commit on 1->0, else accept ops
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;
        dz_d      = dz_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && !dz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (start) begin
            case (mdu_op)
                OP_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    cnt_d = CNT_MUL;
                    dz_d  = 1'b0;
                end
                OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    cnt_d = CNT_MUL;
                    dz_d  = 1'b0;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    cnt_d     = CNT_DIV;
                    dz_d      = (rt_val == '0);
                end
                OP_MTHI: hi_d = rs_val;
                OP_MTLO: lo_d = rs_val;
                default: ;
            endcase
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
            dz_q      <= dz_d;
        end
    end

    assign busy = (cnt_q != '0);

    // Combinational HI/LO read port
    always_comb begin
        case (mdu_op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] out_w;

    int checks = 0;
    int errors = 0;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .out(out_w)
    );

    always #5 clk = ~clk;

    // drive one op across a start edge; returns at the negedge of cycle 1
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; rs_val = '0; rt_val = '0;
    endtask

    // count busy cycles from now; bounded
    task automatic wait_busy(output int n);
        n = 0;
        #1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] op, output logic [31:0] v);
        @(negedge clk);
        mdu_op = op;
        #1;
        v = out_w;
        mdu_op = 4'd0;
    endtask

    task automatic chk_hilo(input string nm, input logic [31:0] eh,
                            input logic [31:0] el);
        logic [31:0] v;
        rd(4'd5, v);
        checks++;
        if (v !== eh) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", nm, v, eh);
        end
        rd(4'd6, v);
        checks++;
        if (v !== el) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", nm, v, el);
        end
    endtask

    task automatic chk_busy_n(input string nm, input int want);
        int n;
        wait_busy(n);
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", nm, n, want);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #3;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        chk_hilo("reset", 32'h0, 32'h0);
        rd(4'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset out op0: got %h want 0", v);
        end
    endtask

    task automatic test_mult;
        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        chk_busy_n("mult", 5);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        chk_busy_n("multu", 5);
        chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk_busy_n("div", 10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd4, 32'd7, 32'd2);
        chk_busy_n("divu", 10);
        chk_hilo("divu", 32'd1, 32'd3);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_busy_n("div_ovf", 10);
        chk_hilo("div_ovf", 32'h0, 32'h8000_0000);
    endtask

    task automatic test_div_zero;
        issue(4'd7, 32'h1234_5678, 32'h0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi busy: got %b want 0", busy);
        end
        issue(4'd8, 32'h9ABC_DEF0, 32'h0);
        chk_hilo("mtx", 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'd3, 32'd55, 32'd0);
        chk_busy_n("divz", 10);
        chk_hilo("divz", 32'h1234_5678, 32'h9ABC_DEF0);
    endtask

    task automatic test_run_ignore;
        issue(4'd1, 32'd3, 32'd4);
        start = 1'b1; mdu_op = 4'd8; rs_val = 32'h55;
        @(negedge clk);
        mdu_op = 4'd1; rs_val = 32'd7; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd6; rs_val = '0; rt_val = '0;
        #1;
        checks++;
        if (out_w !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL run mflo stale: got %h want 9abcdef0", out_w);
        end
        mdu_op = 4'd0;
        chk_busy_n("run_ignore", 3);
        chk_hilo("run_ignore", 32'h0, 32'd12);
    endtask

    task automatic test_back_to_back;
        issue(4'd2, 32'd3, 32'd5);
        chk_busy_n("b2b_mul", 5);
        start = 1'b1; mdu_op = 4'd4; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; rs_val = '0; rt_val = '0;
        chk_busy_n("b2b_div", 10);
        chk_hilo("b2b", 32'd2, 32'd14);
    endtask

    task automatic test_reset_mid;
        int bad;
        issue(4'd7, 32'hDEAD, 32'h0);
        issue(4'd8, 32'hBEEF, 32'h0);
        issue(4'd4, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        mdu_op = 4'd5;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_w !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy %b hi %h want 0/0", busy, out_w);
        end
        mdu_op = 4'd6;
        #1;
        checks++;
        if (out_w !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid lo: got %h want 0", out_w);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (busy !== 1'b0 || out_w !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid late commit: %0d bad cycles want 0", bad);
        end
        mdu_op = 4'd0;
        chk_hilo("reset_mid", 32'h0, 32'h0);
    endtask

    task automatic test_read_idle;
        issue(4'd7, 32'hA5A5_A5A5, 32'h0);
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd5;
        #1;
        checks++;
        if (out_w !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mfhi same cycle: got %h want a5a5a5a5", out_w);
        end
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mfhi busy: got %b want 0", busy);
        end
        checks++;
        if (out_w !== 32'h0) begin
            errors++;
            $display("FAIL op0 out: got %h want 0", out_w);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_run_ignore();
        test_back_to_back();
        test_reset_mid();
        test_read_idle();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
